date_scheduler: RTL and testbench

DATE_SCHEDULER -- requirements
Module: date_scheduler

---
 rtl/date_scheduler.sv | 104 ++++++++++
 tb/tb_date_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/date_scheduler.sv
// Two-requester date advancer on a 30-day/12-month calendar.
// Requests are granted round-robin in IDLE. NORM then folds the sum down by 30 per cycle.
module date_scheduler #(
  parameter int YEAR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [5:0]        n0,
  input  logic              req1,
  input  logic [5:0]        n1,
  input  logic              load,
  input  logic [4:0]        set_day,
  input  logic [3:0]        set_month,
  input  logic [YEAR_W-1:0] set_year,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t     state;
  logic [6:0] sum;
  logic       prio1;   // set when requester 1 wins the next tie
  logic       valid_load;

  assign valid_load = (set_day >= 5'd1) && (set_day <= 5'd30) &&
                      (set_month >= 4'd1) && (set_month <= 4'd12);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state == IDLE && !load) begin
      if (req0 && req1) begin
        gnt0 = !prio1;
        gnt1 = prio1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum   <= '0;
      prio1 <= 1'b0;
      err   <= 1'b0;
      day   <= 5'd1;
      month <= 4'd1;
      year  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (valid_load) begin
              day   <= set_day;
              month <= set_month;
              year  <= set_year;
            end else begin
              err <= 1'b1;
            end
          end else if (gnt0) begin
            sum   <= 7'(day) + 7'(n0);
            prio1 <= 1'b1;
            state <= NORM;
          end else if (gnt1) begin
            sum   <= 7'(day) + 7'(n1);
            prio1 <= 1'b0;
            state <= NORM;
          end
        end
        NORM: begin
          if (sum > 7'd30) begin
            sum <= sum - 7'd30;
            if (month == 4'd12) begin
              month <= 4'd1;
              year  <= year + YEAR_W'(1);
            end else begin
              month <= month + 4'd1;
            end
          end else begin
            day   <= sum[4:0];
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_date_scheduler.sv
// Directed bench for date_scheduler: a table of load/advance vectors plus hand-written
// sequences for load priority, round-robin fairness and reset mid-operation.
module tb_date_scheduler;
  localparam int YEAR_W = 8;

  logic              clk = 1'b0;
  logic              rst, req0, req1, load;
  logic [5:0]        n0, n1;
  logic [4:0]        set_day;
  logic [3:0]        set_month;
  logic [YEAR_W-1:0] set_year;
  logic              gnt0, gnt1, busy, done, err;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;

  int n_chk = 0;
  int n_fail = 0;

  date_scheduler #(.YEAR_W(YEAR_W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .n0(n0), .req1(req1), .n1(n1),
    .load(load), .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .err(err),
    .day(day), .month(month), .year(year)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_date(input string nm, input int ed, input int em, input int ey);
    check({nm, " day"}, int'(day), ed);
    check({nm, " month"}, int'(month), em);
    check({nm, " year"}, int'(year), ey);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load cycle; ends at the negedge of the following cycle.
  task automatic do_load(input string nm, input int sd, input int sm, input int sy,
                         input int exp_err, input int ed, input int em, input int ey);
    load = 1'b1; set_day = 5'(sd); set_month = 4'(sm); set_year = YEAR_W'(sy);
    @(negedge clk);
    check({nm, " no gnt on load"}, int'(gnt0 | gnt1), 0);
    tick();
    load = 1'b0;
    @(negedge clk);
    check({nm, " err"}, int'(err), exp_err);
    check_date({nm, " after load"}, ed, em, ey);
  endtask

  // Called at the negedge of the grant cycle; waits for done and checks latency and date.
  task automatic finish(input string nm, input int k, input int ed, input int em, input int ey);
    int c;
    bit got;
    got = 1'b0;
    for (c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check({nm, " done seen"}, int'(got), 1);
    check({nm, " done cycle"}, c, k + 2);
    check_date({nm, " final"}, ed, em, ey);
    tick();
  endtask

  task automatic advance(input string nm, input bit r, input int n, input int k,
                         input int ed, input int em, input int ey);
    if (r) begin req1 = 1'b1; n1 = 6'(n); end
    else   begin req0 = 1'b1; n0 = 6'(n); end
    @(negedge clk);
    check({nm, " gnt0"}, int'(gnt0), r ? 0 : 1);
    check({nm, " gnt1"}, int'(gnt1), r ? 1 : 0);
    finish(nm, k, ed, em, ey);
  endtask

  typedef struct {
    bit ld; int sd; int sm; int sy;
    bit r;  int n;  int k;
    int ed; int em; int ey;
  } vec_t;

  vec_t vt[6];
  bit   gq[$];

  initial begin
    vt[0] = '{1'b0,  0,  0,   0, 1'b0,  5, 0,  6,  1, 0};
    vt[1] = '{1'b1, 28, 11,   7, 1'b1, 63, 3,  1,  2, 8};
    vt[2] = '{1'b1, 30,  5,   3, 1'b0,  0, 0, 30,  5, 3};
    vt[3] = '{1'b0,  0,  0,   0, 1'b1,  1, 1,  1,  6, 3};
    vt[4] = '{1'b1, 15, 12, 255, 1'b0, 20, 1,  5,  1, 0};
    vt[5] = '{1'b0,  0,  0,   0, 1'b1, 63, 2,  8,  3, 0};

    rst = 1'b1; req0 = 1'b1; req1 = 1'b0; n0 = 6'd3; n1 = '0; load = 1'b0;
    set_day = '0; set_month = '0; set_year = '0;

    // Reset held with a request pending: no grant may escape
    tick();
    @(negedge clk);
    check("gnt0 during rst", int'(gnt0), 0);
    check("gnt1 during rst", int'(gnt1), 0);
    tick();
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset err", int'(err), 0);
    check_date("reset", 1, 1, 0);
    tick();

    foreach (vt[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vt[i].ld) begin
        do_load(nm, vt[i].sd, vt[i].sm, vt[i].sy, 0, vt[i].sd, vt[i].sm, vt[i].sy);
        tick();
      end
      advance(nm, vt[i].r, vt[i].n, vt[i].k, vt[i].ed, vt[i].em, vt[i].ey);
    end

    // Invalid load wins over a pending request; request granted the next cycle
    req0 = 1'b1; n0 = 6'd2;
    do_load("badday", 31, 1, 9, 1, 8, 3, 0);
    check("badday gnt0 next cycle", int'(gnt0), 1);
    finish("badday adv", 0, 10, 3, 0);
    do_load("badmonth", 5, 13, 1, 1, 10, 3, 0);
    tick();
    @(negedge clk);
    check("err single pulse", int'(err), 0);
    tick();

    // Round-robin with both requests held from reset
    rst = 1'b1;
    tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; n0 = 6'd1; n1 = 6'd1;
    begin
      int dones;
      int both;
      dones = 0; both = 0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (gnt0 | gnt1) gq.push_back(gnt1);
        if (gnt0 & gnt1) both++;
        if (done) dones++;
        if (dones == 4) break;
        tick();
      end
      tick();
      req0 = 1'b0; req1 = 1'b0;
      check("rr done count", dones, 4);
      check("rr one-hot", both, 0);
      check("rr grant count", gq.size(), 4);
      for (int g = 0; g < 4 && g < gq.size(); g++)
        check($sformatf("rr grant %0d", g), int'(gq[g]), g % 2);
      @(negedge clk);
      check("rr final day", int'(day), 5);
    end
    tick();

    // Reset in cycle T+2 of a 40-day advance from 20/3/0
    do_load("midrst", 20, 3, 0, 0, 20, 3, 0);
    tick();
    req0 = 1'b1; n0 = 6'd40;
    @(negedge clk);
    check("midrst gnt0", int'(gnt0), 1);
    tick();
    req0 = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst gnt0 in rst", int'(gnt0), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst done", int'(done), 0);
    check("midrst busy", int'(busy), 0);
    check_date("midrst", 1, 1, 0);
    tick();
    @(negedge clk);
    check("midrst no late done", int'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
